ram_16x8: RTL and testbench
===========================

RAM_16X8 -- requirements
Module: ram_16x8

Interface
REQ-001 The block SHALL expose parameter ADDR_WIDTH, default 4, address bus width.
REQ-002 The block SHALL expose parameter DATA_WIDTH, default 8, data word width.
REQ-003 The block SHALL expose parameter DEPTH, default 16 (2**ADDR_WIDTH), number of words.
REQ-004 The block SHALL have port clk, input, 1 bit, single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-006 The block SHALL have port wr_enb, input, 1 bit, write enable.
REQ-007 The block SHALL have port wr_addr, input, ADDR_WIDTH, write address.
REQ-008 The block SHALL have port wr_data, input, DATA_WIDTH, write data.
REQ-009 The block SHALL have port rd_enb, input, 1 bit, read enable.
REQ-010 The block SHALL have port rd_addr, input, ADDR_WIDTH, read address.
REQ-011 The block SHALL have port rd_data, output, DATA_WIDTH, registered read data.
REQ-012 The block SHALL have port rd_valid, output, 1 bit, high for the cycle after an accepted read.

Function
REQ-013 Write: on a rising edge with wr_enb=1 and rst=0, mem[wr_addr] SHALL take wr_data; wr_enb=0 leaves memory unchanged.
REQ-014 Read: on a rising edge with rd_enb=1 and rst=0, rd_data SHALL take mem[rd_addr] (1-cycle latency) and rd_valid SHALL become 1.
REQ-015 With rd_enb=0, rd_data SHALL hold its last value and rd_valid SHALL become 0.
REQ-016 Simultaneous read and write to different addresses SHALL both complete in the same cycle.
REQ-017 Simultaneous read and write to the same address SHALL return the pre-write (old) contents unless RAM_WR_FWD_EN is defined.
REQ-018 Repeated writes to one address SHALL leave only the last value; repeated reads SHALL be non-destructive.
REQ-019 All DEPTH addresses SHALL be writable and readable; there is no out-of-range address and no wrap handling beyond the address width.

Reset
REQ-020 When rst=1 at a rising edge, every memory word SHALL be cleared to 0, and rd_data and rd_valid SHALL be cleared to 0.
REQ-021 rst SHALL take priority over wr_enb and rd_enb in the same cycle; the write and read are discarded.
REQ-022 Reset asserted mid-operation SHALL take effect at the next rising edge; the cycle after rst deasserts SHALL accept normal operations.

Configuration
REQ-023 Macro RAM_WR_FWD_EN SHALL select write-to-read forwarding.
- Defined: same-cycle same-address read returns wr_data (new data).
- Undefined: the read returns old memory contents.
- All other behaviour is identical in both builds.

Structure
REQ-024 ADDR_WIDTH, DATA_WIDTH and DEPTH defaults SHALL live in a shared package ram_pkg, used as parameter defaults.
REQ-025 The memory SHALL be a flat DEPTH x DATA_WIDTH register array inside ram_16x8; no sub-module is required. The forwarding mux is inline logic.

Verification
REQ-026 Reset, then fill: write addr i with a random value for i=0..15 while reading addr i-1 each cycle -> each rd_data equals the value written to that address, including addr 15 on the final read.
REQ-027 Write only: addr 7 <- 56, then read addr 7 -> rd_data=56 and rd_valid=1 one cycle later. While no read is issued, rd_data is unchanged.
REQ-028 Overwrite: write addr 4 with 0x11, 0x22, 0x33, 0x44 on consecutive cycles while reading addr 4 every cycle.
- Without the macro: reads lag by one value.
- With RAM_WR_FWD_EN: reads return 0x11..0x44 in step with the writes.
- The final read returns 0x44.
REQ-029 Mid-operation reset: pulse rst with wr_enb=1 (addr 2 <- 0xAA) -> the write is discarded; rd_data and rd_valid are 0; a subsequent read of any address returns 0.
REQ-030 Read during write to a different address: write addr 3 <- 0x5A while reading addr 9 (holding 0x0F) -> rd_data=0x0F, and a later read of addr 3 returns 0x5A.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared defaults for ram_16x8 (address width, data width, depth)
package ram_pkg;
  localparam int RAM_ADDR_WIDTH = 4;
  localparam int RAM_DATA_WIDTH = 8;
  localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;
endpackage

// File: rtl/ram_16x8_if.sv
// ram_16x8_if: RAM bus; master drives wr_enb/wr_addr/wr_data/rd_enb/rd_addr, slave returns rd_data/rd_valid
interface ram_16x8_if import ram_pkg::*; #(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH
);
  logic                  wr_enb;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_enb;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  modport master (output wr_enb, wr_addr, wr_data, rd_enb, rd_addr, input rd_data, rd_valid);
  modport slave (input wr_enb, wr_addr, wr_data, rd_enb, rd_addr, output rd_data, rd_valid);
endinterface

// File: rtl/ram_16x8.sv
// ram_16x8: DEPTH x DATA_WIDTH sync RAM, ports clk, rst (sync active-high), bus (slave: write port, registered read port with rd_valid); define RAM_WR_FWD_EN to forward same-address same-cycle write data to the read
module ram_16x8 import ram_pkg::*; #(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int DEPTH = RAM_DEPTH
) (
  input logic clk,
  input logic rst,
  ram_16x8_if.slave bus
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_word;
  assign wr_addr = bus.wr_addr;
  assign rd_addr = bus.rd_addr;
`ifdef RAM_WR_FWD_EN
  assign rd_word = (bus.wr_enb && wr_addr == rd_addr) ? bus.wr_data : mem[rd_addr];
`else
  assign rd_word = mem[rd_addr];
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      bus.rd_data <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      if (bus.wr_enb) mem[wr_addr] <= bus.wr_data;
      if (bus.rd_enb) bus.rd_data <= rd_word;
      bus.rd_valid <= bus.rd_enb;
    end
  end
endmodule

// File: tb/tb_ram_16x8.sv
// tb_ram_16x8: directed and random checks of ram_16x8 against an array reference model
module tb_ram_16x8;
`ifdef RAM_WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  ram_16x8_if bus ();
  ram_16x8 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  logic [7:0] ref_mem [16];
  logic [7:0] exp_data = 8'h00;
  logic       exp_valid = 1'b0;
  logic [7:0] v [16];
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic rs, input logic we, input logic [3:0] wa, input logic [7:0] wd,
                      input logic re, input logic [3:0] ra);
    rst = rs;
    bus.wr_enb = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_enb = re;
    bus.rd_addr = ra;
    @(posedge clk);
    if (rs) begin
      foreach (ref_mem[i]) ref_mem[i] = 8'h00;
      exp_data = 8'h00;
      exp_valid = 1'b0;
    end else begin
      if (re) exp_data = (FWD && we && wa == ra) ? wd : ref_mem[ra];
      exp_valid = re;
      if (we) ref_mem[wa] = wd;
    end
    #1;
    check("model_rd_data", bus.rd_data, exp_data);
    check("model_rd_valid", {7'b0, bus.rd_valid}, {7'b0, exp_valid});
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.wr_enb = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_enb = 1'b0;
    bus.rd_addr = '0;
    step(1, 1, 4'd0, 8'hFF, 1, 4'd0);
    check("reset_rd_data", bus.rd_data, 8'h00);
    check("reset_rd_valid", {7'b0, bus.rd_valid}, 8'h00);
    foreach (v[i]) v[i] = 8'($urandom);
    for (int i = 0; i <= 16; i++) begin
      step(0, i < 16, 4'(i), i < 16 ? v[i & 15] : 8'h00, i > 0, 4'(i - 1));
      if (i > 0) check("fill_read", bus.rd_data, v[i - 1]);
    end
    step(0, 1, 4'd7, 8'd56, 0, 4'd0);
    check("hold_rd_data", bus.rd_data, v[15]);
    check("hold_rd_valid", {7'b0, bus.rd_valid}, 8'h00);
    step(0, 0, 4'd0, 8'h00, 1, 4'd7);
    check("read7_data", bus.rd_data, 8'd56);
    check("read7_valid", {7'b0, bus.rd_valid}, 8'h01);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 4'd4, 8'(8'h11 * (k + 1)), 1, 4'd4);
      check("overwrite_read", bus.rd_data, FWD ? 8'(8'h11 * (k + 1)) : (k == 0 ? v[4] : 8'(8'h11 * k)));
    end
    step(0, 0, 4'd0, 8'h00, 1, 4'd4);
    check("overwrite_final", bus.rd_data, 8'h44);
    step(1, 1, 4'd2, 8'hAA, 1, 4'd5);
    check("midrst_rd_data", bus.rd_data, 8'h00);
    check("midrst_rd_valid", {7'b0, bus.rd_valid}, 8'h00);
    step(0, 0, 4'd0, 8'h00, 1, 4'd2);
    check("midrst_read2", bus.rd_data, 8'h00);
    step(0, 0, 4'd0, 8'h00, 1, 4'd13);
    check("midrst_read13", bus.rd_data, 8'h00);
    step(0, 1, 4'd9, 8'h0F, 0, 4'd0);
    step(0, 1, 4'd3, 8'h5A, 1, 4'd9);
    check("diff_addr_read9", bus.rd_data, 8'h0F);
    step(0, 0, 4'd0, 8'h00, 1, 4'd3);
    check("diff_addr_read3", bus.rd_data, 8'h5A);
    for (int n = 0; n < 400; n++) begin
      logic [3:0] wa;
      logic [3:0] ra;
      wa = 4'($urandom);
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom);
      step($urandom_range(0, 39) == 0, 1'($urandom), wa, 8'($urandom), 1'($urandom), ra);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
